// File: rtl/booth_arbiter.sv
// booth_arbiter
// Round-robin front end that shares one booth multiplier between two
// requesters. A granted request is walked through START / LOAD_A / LOAD_B on
// the m_* bus, then the block waits for the multiplier's done flag and
// returns the product on res together with a one-cycle ack for the winner.
//
// Optional watchdog: define BOOTH_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TMO cycles (err pulse, no ack). Without the macro err is tied low and WAIT
// waits indefinitely.
module booth_arbiter #(
  parameter int W   = 8,
  parameter int TMO = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic signed [W-1:0]   a0,
  input  logic signed [W-1:0]   b0,
  input  logic signed [W-1:0]   a1,
  input  logic signed [W-1:0]   b1,
  output logic                  ack0,
  output logic                  ack1,
  output logic signed [2*W-1:0] res,
  output logic                  err,
  output logic                  busy,
  output logic                  m_start,
  output logic                  m_get,
  output logic [W-1:0]          m_in,
  input  logic                  m_ready,
  input  logic signed [2*W-1:0] m_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_LOAD_A = 3'd2;
  localparam logic [2:0] S_LOAD_B = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic                  r_gnt;
  logic                  r_last_gnt;
  logic                  r_seen_low;
  logic signed [2*W-1:0] r_res;

  logic                  w_any_req;
  logic                  w_gnt_nxt;
  logic                  w_done;
  logic                  w_tmo;
  logic signed [W-1:0]   w_op_a;
  logic signed [W-1:0]   w_op_b;

  // A TMO below 1 is not a meaningful watchdog limit; it is only consumed
  // when the watchdog is built in.
  if (TMO < 1) begin : g_tmo_guard
  end

  assign w_any_req = req0 | req1;
  // Contention goes to whoever was not served last; a lone request wins outright.
  assign w_gnt_nxt = (req0 & req1) ? ~r_last_gnt : req1;
  assign w_op_a    = r_gnt ? a1 : a0;
  assign w_op_b    = r_gnt ? b1 : b0;
  // A high m_ready only counts once a low has been observed after START,
  // so a done flag still standing from the previous product is ignored.
  assign w_done    = (r_state == S_WAIT) & r_seen_low & m_ready;

  // Next-state selection for the request/load/wait/ack sequence
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_state_nxt = S_START;
      S_START:  w_state_nxt = S_LOAD_A;
      S_LOAD_A: w_state_nxt = S_LOAD_B;
      S_LOAD_B: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done) begin
          w_state_nxt = S_DONE;
        end else if (w_tmo) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight without an ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant latch (sampled only in IDLE) and round-robin history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt      <= 1'b0;
      r_last_gnt <= 1'b1;
    end else begin
      if ((r_state == S_IDLE) && w_any_req) begin
        r_gnt <= w_gnt_nxt;
      end
      if ((r_state == S_DONE) || w_tmo) begin
        r_last_gnt <= r_gnt;
      end
    end
  end

  // Track whether the multiplier has dropped m_ready since this operation started
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seen_low <= 1'b0;
    end else if (r_state == S_START) begin
      r_seen_low <= 1'b0;
    end else if (((r_state == S_LOAD_A) || (r_state == S_LOAD_B) ||
                  (r_state == S_WAIT)) && !m_ready) begin
      r_seen_low <= 1'b1;
    end
  end

  // Product capture on the WAIT->DONE edge so res is already valid while ack is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res <= '0;
    end else if (w_done) begin
      r_res <= m_out;
    end
  end

  // Moore output decode; IDLE (and therefore reset) drives every strobe low
  always_comb begin
    busy    = (r_state != S_IDLE);
    m_start = (r_state == S_START);
    m_get   = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    ack0    = (r_state == S_DONE) && !r_gnt;
    ack1    = (r_state == S_DONE) &&  r_gnt;
    case (r_state)
      S_LOAD_A:         m_in = w_op_a;
      S_LOAD_B, S_WAIT: m_in = w_op_b;
      default:          m_in = '0;
    endcase
  end

  assign res = r_res;

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = (TMO < 2) ? 1 : $clog2(TMO);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // The TMO-th WAIT cycle without completion aborts the operation
  assign w_tmo = (r_state == S_WAIT) && !w_done && (r_cnt == CW'(TMO - 1));
  assign err   = r_err;

  // WAIT cycle counter: cleared on entry to WAIT, advanced each WAIT cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == S_LOAD_B) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // err is a one-cycle pulse in the cycle after the abort, when busy is already low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_tmo;
    end
  end
`else
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

endmodule
